sobel_window_feeder: RTL and testbench
======================================

Name: sobel_window_feeder

Overview:
Upstream stage of the stochastic Sobel core (stochWrapper). Accepts a raster-order pixel stream, keeps two line buffers plus a 3x3 shift window, and for every interior pixel presents the 8 neighbours (pixel_1..pixel_9, no centre) to the core. It pulses start, waits for done, and forwards the core's z_bin result with its edge-image coordinates. The input stream is stalled while the core computes.

Parameters:
ROWS, 3, source image rows (>=3)
COLS, 3, source image columns (>=3)
PIX_W, 8, pixel width in bits
ROW_W, $clog2(ROWS), row counter width (derived)
COL_W, $clog2(COLS), column counter width (derived)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  input pixel valid
in_ready  out  1  feeder can accept a pixel
in_pixel  in  PIX_W  source pixel, raster order
pixel_1_bin..pixel_4_bin, pixel_6_bin..pixel_9_bin  out  PIX_W each  window to core (1=top-left, 2=top-mid, 3=top-right, 4=mid-left, 6=mid-right, 7=bottom-left, 8=bottom-mid, 9=bottom-right)
core_start  out  1  one-cycle start pulse to core
core_done  in  1  core result ready (single-cycle pulse)
core_z  in  PIX_W  core result, sampled when core_done=1
out_valid  out  1  one-cycle result strobe
out_data  out  PIX_W  edge value
out_row  out  ROW_W  edge-image row (0..ROWS-3)
out_col  out  COL_W  edge-image column (0..COLS-3)
frame_done  out  1  pulse coincident with the last out_valid of a frame

Behaviour:
- Reset (reset=0, async): state=ACCEPT, row=col=0, all window regs 0, core_start=0, out_valid=0, out_data/out_row/out_col=0, frame_done=0. in_ready=1 one cycle after release. Line buffer RAM is not cleared (never read before being rewritten in a frame).
- FSM states: ACCEPT, START, WAIT. in_ready=1 only in ACCEPT.
- ACCEPT, handshake in_valid&in_ready at (row r, col c):
  - top=lb1[c], mid=lb0[c], bot=in_pixel.
  - Window shifts left one column; new right column = {top, mid, bot}.
  - lb1[c]<=lb0[c]; lb0[c]<=in_pixel.
  - col increments; wraps to 0 at COLS-1 with row++. Row wraps to 0 after ROWS-1.
  - If r>=2 and c>=2: latch er=r-2, ec=c-2, last=(r==ROWS-1 && c==COLS-1), go to START; else stay in ACCEPT.
- START: core_start=1 for exactly this cycle; window outputs stable; next state is WAIT.
- WAIT: window outputs held stable. core_done=1 -> next cycle out_valid=1, out_data=core_z, out_row=er, out_col=ec, frame_done=last; state returns to ACCEPT in the same cycle as out_valid.
- core_done outside WAIT (including during START) is ignored.
- No output backpressure.
- Throughput: at most one window per core computation. Latency from accepting the completing pixel to core_start = 1 cycle.
- in_valid low: no state change, counters hold.
- Reset asserted mid-frame or mid-WAIT: the partial frame is discarded. After release, the next accepted pixel is (0,0).
- Windows never span a row wrap: the c>=2 gate excludes the first two columns of each row.

Decomposition:
- sobel_pkg: PIX_W constant, pixel typedef, FSM state enum.
- One sub-module, sobel_line_buffer: COLS-deep dual-row storage. Single read/write per column index per accepted pixel; returns {lb1[c], lb0[c]} combinationally.

Test Plan:
- 3x3 frame 0x10,0x20,...,0x90 -> one core_start after the 9th pixel. Window: p1=10 p2=20 p3=30 p4=40 p6=60 p7=70 p8=80 p9=90. Model returns 0xAB -> out_valid with out_data=AB, row=0, col=0, frame_done=1.
- 4x5 frame, pixel value = 16*r+c, model core returns p9-p1 -> exactly 6 results in order (0,0),(0,1),(0,2),(1,0),(1,1),(1,2), each equal to 0x22; frame_done only on the last result.
- Core done delayed 518 cycles -> in_ready=0 and window outputs constant throughout WAIT; no pixel is lost.
- Spurious core_done during ACCEPT and START -> no out_valid, FSM unchanged.
- in_valid toggling randomly over a 4x5 frame -> results identical to the gap-free run.
- Reset low during WAIT of frame 1, then a full 3x3 frame -> a single correct result; no stale out_valid.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared types for the Sobel window feeder: pixel width, pixel type, FSM states.
// Latency: declarations only, no logic.
// Backpressure: not applicable.
package sobel_pkg;

    localparam int PIX_W = 8;

    typedef logic [PIX_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_START  = 2'd1,
        ST_WAIT   = 2'd2
    } feeder_state_t;

endpackage

// File: rtl/sobel_line_buffer.sv
// Two-row line buffer, COLS deep; lb1 holds row r-2 and lb0 holds row r-1 at each column.
// Latency: read is combinational on col; write lands on the rising edge when wr_en=1.
// Backpressure: none; the caller writes exactly once per accepted pixel.
// Ports: clk, wr_en, col (column index), wr_pixel (new pixel), top (lb1[col]), mid (lb0[col]).
module sobel_line_buffer #(
    parameter int COLS  = 3,
    parameter int PIX_W = 8,
    parameter int COL_W = $clog2(COLS)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [COL_W-1:0] col,
    input  logic [PIX_W-1:0] wr_pixel,
    output logic [PIX_W-1:0] top,
    output logic [PIX_W-1:0] mid
);
    import sobel_pkg::*;

    logic [PIX_W-1:0] lb0 [COLS];
    logic [PIX_W-1:0] lb1 [COLS];

    assign top = lb1[col];
    assign mid = lb0[col];

    // Plain storage without reset: every entry is rewritten before it is read in a frame.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            lb1[col] <= lb0[col];
            lb0[col] <= wr_pixel;
        end
    end

endmodule

// File: rtl/sobel_window_feeder.sv
// Raster pixel stream -> 3x3 neighbour window for the stochastic Sobel core, result forwarding.
// Latency: core_start 1 cycle after the window-completing pixel; out_valid 1 cycle after core_done.
// Backpressure: in_ready drops from window completion until the core result is taken; no output stall.
// Ports: clk/reset (async active-low), in_valid/in_ready/in_pixel stream, pixel_*_bin window,
//        core_start/core_done/core_z core handshake, out_valid/out_data/out_row/out_col/frame_done result.
module sobel_window_feeder #(
    parameter int ROWS  = 3,
    parameter int COLS  = 3,
    parameter int PIX_W = 8,
    parameter int ROW_W = $clog2(ROWS),
    parameter int COL_W = $clog2(COLS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pixel,
    output logic [PIX_W-1:0] pixel_1_bin,
    output logic [PIX_W-1:0] pixel_2_bin,
    output logic [PIX_W-1:0] pixel_3_bin,
    output logic [PIX_W-1:0] pixel_4_bin,
    output logic [PIX_W-1:0] pixel_6_bin,
    output logic [PIX_W-1:0] pixel_7_bin,
    output logic [PIX_W-1:0] pixel_8_bin,
    output logic [PIX_W-1:0] pixel_9_bin,
    output logic             core_start,
    input  logic             core_done,
    input  logic [PIX_W-1:0] core_z,
    output logic             out_valid,
    output logic [PIX_W-1:0] out_data,
    output logic [ROW_W-1:0] out_row,
    output logic [COL_W-1:0] out_col,
    output logic             frame_done
);
    import sobel_pkg::*;

    feeder_state_t    state;
    feeder_state_t    state_next;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] edge_row;
    logic [COL_W-1:0] edge_col;
    logic             edge_last;
    logic [PIX_W-1:0] lb_top;
    logic [PIX_W-1:0] lb_mid;
    logic             accept;
    logic             col_last;
    logic             row_last;
    logic             window_full;

    // win[v][h]: v = 0 top / 1 middle / 2 bottom, h = 0 left / 1 centre / 2 right.
    logic [PIX_W-1:0] win [3][3];

    assign accept      = in_valid && (state == ST_ACCEPT);
    assign col_last    = (col == COL_W'(COLS - 1));
    assign row_last    = (row == ROW_W'(ROWS - 1));
    // Gating on col>=2 keeps a window from straddling the previous row's tail.
    assign window_full = (row >= ROW_W'(2)) && (col >= COL_W'(2));

    sobel_line_buffer #(
        .COLS  (COLS),
        .PIX_W (PIX_W),
        .COL_W (COL_W)
    ) u_line_buffer (
        .clk      (clk),
        .wr_en    (accept),
        .col      (col),
        .wr_pixel (in_pixel),
        .top      (lb_top),
        .mid      (lb_mid)
    );

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        core_start = 1'b0;
        unique case (state)
            ST_ACCEPT: begin
                in_ready = 1'b1;
                if (accept && window_full) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                core_start = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (core_done) begin
                    state_next = ST_ACCEPT;
                end
            end
            default: state_next = ST_ACCEPT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_ACCEPT;
            row        <= '0;
            col        <= '0;
            edge_row   <= '0;
            edge_col   <= '0;
            edge_last  <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_row    <= '0;
            out_col    <= '0;
            frame_done <= 1'b0;
            for (int v = 0; v < 3; v++) begin
                for (int h = 0; h < 3; h++) begin
                    win[v][h] <= '0;
                end
            end
        end else begin
            state      <= state_next;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (accept) begin
                for (int v = 0; v < 3; v++) begin
                    win[v][0] <= win[v][1];
                    win[v][1] <= win[v][2];
                end
                win[0][2] <= lb_top;
                win[1][2] <= lb_mid;
                win[2][2] <= in_pixel;
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
                if (window_full) begin
                    edge_row  <= row - ROW_W'(2);
                    edge_col  <= col - COL_W'(2);
                    edge_last <= row_last && col_last;
                end
            end
            if ((state == ST_WAIT) && core_done) begin
                out_valid  <= 1'b1;
                out_data   <= core_z;
                out_row    <= edge_row;
                out_col    <= edge_col;
                frame_done <= edge_last;
            end
        end
    end

    assign pixel_1_bin = win[0][0];
    assign pixel_2_bin = win[0][1];
    assign pixel_3_bin = win[0][2];
    assign pixel_4_bin = win[1][0];
    assign pixel_6_bin = win[1][2];
    assign pixel_7_bin = win[2][0];
    assign pixel_8_bin = win[2][1];
    assign pixel_9_bin = win[2][2];

endmodule

// File: tb/tb_sobel_window_feeder.sv
module tb_sobel_window_feeder;

    localparam int ROWS = 4;
    localparam int COLS = 5;
    localparam int RW   = $clog2(ROWS);
    localparam int CW   = $clog2(COLS);

    typedef struct packed {
        logic [7:0] p1, p2, p3, p4, p6, p7, p8, p9;
    } win_t;

    typedef struct packed {
        logic [7:0]    data;
        logic [RW-1:0] row;
        logic [CW-1:0] col;
        logic          fd;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_pixel;
    logic [7:0]    p1, p2, p3, p4, p6, p7, p8, p9;
    logic          core_start;
    logic          core_done;
    logic [7:0]    core_z;
    logic          out_valid;
    logic [7:0]    out_data;
    logic [RW-1:0] out_row;
    logic [CW-1:0] out_col;
    logic          frame_done;

    int         checks;
    int         errors;
    exp_t       exp_q[$];
    win_t       win_q[$];
    logic [7:0] res_log[$];
    logic [7:0] run_a[$];
    logic [7:0] img [ROWS][COLS];
    int         core_mode;
    int         core_delay;
    bit         spurious_en;
    bit         abort_core;
    bit         hung;

    sobel_window_feeder #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .PIX_W (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pixel    (in_pixel),
        .pixel_1_bin (p1),
        .pixel_2_bin (p2),
        .pixel_3_bin (p3),
        .pixel_4_bin (p4),
        .pixel_6_bin (p6),
        .pixel_7_bin (p7),
        .pixel_8_bin (p8),
        .pixel_9_bin (p9),
        .core_start  (core_start),
        .core_done   (core_done),
        .core_z      (core_z),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_row     (out_row),
        .out_col     (out_col),
        .frame_done  (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic win_t dut_win();
        win_t w;
        w = '{p1: p1, p2: p2, p3: p3, p4: p4, p6: p6, p7: p7, p8: p8, p9: p9};
        return w;
    endfunction

    // Neighbourhood of image pixel (r,c) taken as the bottom-right corner.
    function automatic win_t img_win(input int r, input int c);
        win_t w;
        w.p1 = img[r-2][c-2]; w.p2 = img[r-2][c-1]; w.p3 = img[r-2][c];
        w.p4 = img[r-1][c-2];                       w.p6 = img[r-1][c];
        w.p7 = img[r][c-2];   w.p8 = img[r][c-1];   w.p9 = img[r][c];
        return w;
    endfunction

    // Stand-in for the Sobel core: a function sensitive to every neighbour position.
    function automatic logic [7:0] core_fn(input win_t w, input int mode);
        int s;
        if (mode == 0) return 8'(w.p9 - w.p1);
        s = 1 * int'(w.p1) + 3 * int'(w.p2) + 5 * int'(w.p3) + 7 * int'(w.p4)
          + 11 * int'(w.p6) + 13 * int'(w.p7) + 17 * int'(w.p8) + 19 * int'(w.p9);
        return 8'(s);
    endfunction

    task automatic push_expect(input int r, input int c);
        win_t w;
        exp_t e;
        w = img_win(r, c);
        e.data = core_fn(w, core_mode);
        e.row  = RW'(r - 2);
        e.col  = CW'(c - 2);
        e.fd   = (r == ROWS - 1) && (c == COLS - 1);
        win_q.push_back(w);
        exp_q.push_back(e);
    endtask

    // Entered and left at posedge+1.
    task automatic send_pixel(input logic [7:0] v);
        int n;
        if (hung) return;
        in_valid = 1'b1;
        in_pixel = v;
        n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1) begin
            n++;
            if (n > 1500) begin
                checks++; errors++;
                $display("FAIL in_ready_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
                hung = 1'b1;
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input bit gapped, input int npix);
        int k;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (r * COLS + c < npix) begin
                    if (gapped) begin
                        k = $urandom_range(0, 3);
                        repeat (k) begin @(posedge clk); #1; end
                    end
                    if (r >= 2 && c >= 2) push_expect(r, c);
                    send_pixel(img[r][c]);
                end
            end
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || win_q.size() != 0) && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (2) begin @(posedge clk); #1; end
        checks++;
        if (exp_q.size() != 0 || win_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d results and %0d windows outstanding, required 0",
                     name, exp_q.size(), win_q.size());
            exp_q.delete();
            win_q.delete();
        end
    endtask

    task automatic fill_random();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                img[r][c] = 8'($urandom);
    endtask

    task automatic check_reset(input string name);
        checks++;
        if (out_valid !== 1'b0 || core_start !== 1'b0 || frame_done !== 1'b0 ||
            out_data !== 8'h00 || out_row !== '0 || out_col !== '0 || dut_win() !== '0) begin
            errors++;
            $display("FAIL %s: valid=%b start=%b fd=%b data=%h row=%0d col=%0d win=%h, required all zero",
                     name, out_valid, core_start, frame_done, out_data, out_row, out_col, dut_win());
        end
    endtask

    // Core model: checks the presented window, holds it through WAIT, then answers.
    initial begin : core_model
        win_t w;
        win_t ew;
        bit   aborted;
        core_done = 1'b0;
        core_z    = 8'h00;
        forever begin
            @(negedge clk);
            if (core_start === 1'b1) begin
                w = dut_win();
                checks++;
                if (win_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_start: core_start=1 with no window pending");
                end else begin
                    ew = win_q.pop_front();
                    if (w !== ew) begin
                        errors++;
                        $display("FAIL window: got %h, required %h", w, ew);
                    end
                end
                if (spurious_en) begin
                    core_done = 1'b1;
                    core_z    = ~core_fn(w, core_mode);
                end
                @(posedge clk);
                #1;
                core_done = 1'b0;
                aborted = 1'b0;
                for (int i = 0; i < core_delay; i++) begin
                    @(negedge clk);
                    if (abort_core) begin
                        aborted = 1'b1;
                        break;
                    end
                    checks++;
                    if (in_ready !== 1'b0 || core_start !== 1'b0 || out_valid !== 1'b0 || dut_win() !== w) begin
                        errors++;
                        $display("FAIL wait_hold: cycle %0d in_ready=%b start=%b valid=%b win=%h, required 0/0/0 win=%h",
                                 i, in_ready, core_start, out_valid, dut_win(), w);
                    end
                    @(posedge clk);
                    #1;
                end
                if (!aborted && !abort_core) begin
                    core_done = 1'b1;
                    core_z    = core_fn(w, core_mode);
                    @(posedge clk);
                    #1;
                    core_done = 1'b0;
                end
            end else if (spurious_en && in_ready === 1'b1 && $urandom_range(0, 3) == 0) begin
                core_done = 1'b1;
                core_z    = 8'($urandom);
                @(posedge clk);
                #1;
                core_done = 1'b0;
            end
        end
    end

    // Scoreboard monitor.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out: data=%h row=%0d col=%0d with nothing expected",
                             out_data, out_row, out_col);
                end else begin
                    e = exp_q.pop_front();
                    res_log.push_back(out_data);
                    if (out_data !== e.data || out_row !== e.row || out_col !== e.col || frame_done !== e.fd) begin
                        errors++;
                        $display("FAIL result: got data=%h row=%0d col=%0d fd=%b, required data=%h row=%0d col=%0d fd=%b",
                                 out_data, out_row, out_col, frame_done, e.data, e.row, e.col, e.fd);
                    end
                end
            end else if (frame_done !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL frame_done_alone: frame_done=%b with out_valid=0, required 0", frame_done);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : stimulus
        checks      = 0;
        errors      = 0;
        reset       = 1'b0;
        in_valid    = 1'b0;
        in_pixel    = 8'h00;
        core_mode   = 0;
        core_delay  = 2;
        spurious_en = 1'b0;
        abort_core  = 1'b0;
        hung        = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("reset_state");
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL in_ready_after_reset: got %b, required 1", in_ready);
        end
        @(posedge clk);
        #1;

        // Known answer: pixel = 16r+c, core returns p9-p1, every result 0x22.
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                img[r][c] = 8'(16 * r + c);
        core_mode = 0;
        res_log.delete();
        send_frame(1'b0, ROWS * COLS);
        drain("known");
        checks++;
        if (res_log.size() != 6) begin
            errors++;
            $display("FAIL known_count: got %0d results, required 6", res_log.size());
        end
        foreach (res_log[i]) begin
            checks++;
            if (res_log[i] !== 8'h22) begin
                errors++;
                $display("FAIL known_value: result %0d got %h, required 22", i, res_log[i]);
            end
        end

        // Long core latency.
        core_mode  = 1;
        core_delay = 518;
        fill_random();
        send_frame(1'b0, ROWS * COLS);
        drain("long_wait");

        // Spurious core_done in ACCEPT and START.
        core_delay  = 3;
        spurious_en = 1'b1;
        fill_random();
        send_frame(1'b1, ROWS * COLS);
        drain("spurious");
        spurious_en = 1'b0;

        // Same image gap-free and with random in_valid gaps.
        fill_random();
        res_log.delete();
        send_frame(1'b0, ROWS * COLS);
        drain("gapfree");
        run_a = res_log;
        res_log.delete();
        core_delay = 1;
        send_frame(1'b1, ROWS * COLS);
        drain("gapped");
        checks++;
        if (res_log.size() != run_a.size() || run_a.size() != 6) begin
            errors++;
            $display("FAIL gap_count: gapped %0d results, gap-free %0d, required 6 each",
                     res_log.size(), run_a.size());
        end else begin
            foreach (run_a[i]) begin
                checks++;
                if (res_log[i] !== run_a[i]) begin
                    errors++;
                    $display("FAIL gap_match: result %0d gapped %h, gap-free %h", i, res_log[i], run_a[i]);
                end
            end
        end

        // Reset in the middle of WAIT, then a clean frame.
        core_delay = 400;
        fill_random();
        send_frame(1'b0, 2 * COLS + 3);
        repeat (20) begin @(posedge clk); #1; end
        abort_core = 1'b1;
        reset      = 1'b0;
        exp_q.delete();
        win_q.delete();
        @(negedge clk);
        check_reset("reset_mid_wait");
        repeat (3) begin @(posedge clk); #1; end
        abort_core = 1'b0;
        reset      = 1'b1;
        core_delay = 2;
        fill_random();
        res_log.delete();
        send_frame(1'b1, ROWS * COLS);
        drain("after_reset");
        checks++;
        if (res_log.size() != 6) begin
            errors++;
            $display("FAIL after_reset_count: got %0d results, required 6", res_log.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
